nios_2_button_irq_ctrl: RTL

//  Avalon-MM slave controller for one push-button input. Adds a 2-flop synchronizer,
//  a debounce FSM, edge detection, a sticky edge-capture register and a maskable
//  IRQ line, so the Nios II can take button events by interrupt instead of polling.

---
 rtl/nios_2_button_irq_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/nios_2_button_irq_ctrl.sv
// Avalon-MM push-button controller: 2-flop synchronizer, debounce FSM, edge detect,
// sticky W1C edge-capture register and a maskable interrupt line.
module nios_2_button_irq_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned EDGE_TYPE       = 0,
  parameter logic        IDLE_LEVEL      = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  input  logic        in_port
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  typedef enum logic {ST_STABLE, ST_COUNTING} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              s1_q, s2_q;
  logic              level_q, level_d;
  logic              level_prev_q;
  logic              irq_mask_q, irq_mask_d;
  logic              edge_capture_q, edge_capture_d;
  logic [31:0]       readdata_q, readdata_d;

  logic              wr_en;
  logic              fall, rise, edge_det;
  logic              unused_writedata;

  assign wr_en            = chipselect & ~write_n;
  assign unused_writedata = ^writedata[31:1];

  assign fall = level_prev_q & ~level_q;
  assign rise = ~level_prev_q & level_q;

  always_comb begin
    case (EDGE_TYPE)
      0:       edge_det = fall;
      1:       edge_det = rise;
      default: edge_det = fall | rise;
    endcase
  end

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    case (state_q)
      ST_STABLE: begin
        if (s2_q != level_q) begin
          state_d = ST_COUNTING;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      ST_COUNTING: begin
        if (s2_q == level_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          level_d = s2_q;
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A clear and a fresh edge in the same cycle keep the bit set so no event is lost.
  always_comb begin
    irq_mask_d     = irq_mask_q;
    edge_capture_d = edge_capture_q;
    if (wr_en && address == 2'd2) irq_mask_d = writedata[0];
    if (wr_en && address == 2'd3 && writedata[0]) edge_capture_d = 1'b0;
    if (edge_det) edge_capture_d = 1'b1;
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      2'd0:    readdata_d[0] = level_q;
      2'd2:    readdata_d[0] = irq_mask_q;
      2'd3:    readdata_d[0] = edge_capture_q;
      default: readdata_d[0] = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours (s2_q gets the old s1_q, not the new one).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q           <= IDLE_LEVEL;
      s2_q           <= IDLE_LEVEL;
      state_q        <= ST_STABLE;
      cnt_q          <= '0;
      level_q        <= IDLE_LEVEL;
      level_prev_q   <= IDLE_LEVEL;
      irq_mask_q     <= 1'b0;
      edge_capture_q <= 1'b0;
      readdata_q     <= '0;
    end else begin
      s1_q           <= in_port;
      s2_q           <= s1_q;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      level_q        <= level_d;
      level_prev_q   <= level_q;
      irq_mask_q     <= irq_mask_d;
      edge_capture_q <= edge_capture_d;
      readdata_q     <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = edge_capture_q & irq_mask_q;

endmodule
